// File: rtl/mem_stage.sv
// mem_stage: memory-access stage after EX; word load/store on an internal RAM,
// writeback bundle, valid/ready toward EX, sticky halt and a retire counter.
`default_nettype none

module mem_stage #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             CLOCK,
   input  logic             CLEAR,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [15:0]      ex_lo,
   input  logic [15:0]      ex_hi,
   input  logic [15:0]      ex_sdata,
   input  logic [3:0]       ex_dst,
   input  logic [1:0]       ex_wrdst,
   input  logic             ex_load,
   input  logic             ex_store,
   input  logic             ex_halt,
   output logic             wb_valid,
   output logic [15:0]      wb_lo,
   output logic [15:0]      wb_hi,
   output logic [3:0]       wb_dst,
   output logic [1:0]       wb_wrdst,
   output logic             halted,
   output logic [CNT_W-1:0] retire_count
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_LOAD = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t             state_q;
   logic [15:0]        mem_q [DEPTH];
   logic [15:0]        rdata_q;
   logic [15:0]        ld_hi_q;
   logic [3:0]         ld_dst_q;
   logic [1:0]         ld_wrdst_q;
   logic               wb_valid_q;
   logic [15:0]        wb_lo_q;
   logic [15:0]        wb_hi_q;
   logic [3:0]         wb_dst_q;
   logic [1:0]         wb_wrdst_q;
   logic               halted_q;
   logic [CNT_W-1:0]   retire_q;
   logic [CNT_W-1:0]   retire_d;

   logic               accept;
   logic               do_store;
   logic               do_load;
   logic [ADDR_W-1:0]  addr;

   // Halt outranks both memory operations; store outranks load.
   assign ex_ready = (state_q == S_RUN);
   assign accept   = ex_valid && ex_ready;
   assign do_store = accept && !ex_halt && ex_store;
   assign do_load  = accept && !ex_halt && !ex_store && ex_load;
   assign addr     = ex_lo[ADDR_W-1:0];
   assign retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};

   // RAM has no reset; writes are blocked while CLEAR is held.
   always_ff @(posedge CLOCK) begin
      if (do_store && !CLEAR) begin
         mem_q[addr] <= ex_sdata;
      end
      if (do_load) begin
         rdata_q <= mem_q[addr];
      end
   end

   always_ff @(posedge CLOCK or posedge CLEAR) begin
      if (CLEAR) begin
         state_q    <= S_RUN;
         wb_valid_q <= 1'b0;
         wb_lo_q    <= 16'h0000;
         wb_hi_q    <= 16'h0000;
         wb_dst_q   <= 4'h0;
         wb_wrdst_q <= 2'b00;
         halted_q   <= 1'b0;
         retire_q   <= '0;
         ld_hi_q    <= 16'h0000;
         ld_dst_q   <= 4'h0;
         ld_wrdst_q <= 2'b00;
      end else begin
         wb_valid_q <= 1'b0;
         case (state_q)
            S_RUN: begin
               if (do_load) begin
                  ld_hi_q    <= ex_hi;
                  ld_dst_q   <= ex_dst;
                  ld_wrdst_q <= ex_wrdst;
                  state_q    <= S_LOAD;
               end else if (accept) begin
                  wb_valid_q <= 1'b1;
                  wb_lo_q    <= ex_lo;
                  wb_hi_q    <= ex_hi;
                  wb_dst_q   <= ex_dst;
                  wb_wrdst_q <= (ex_store || ex_halt) ? 2'b00 : ex_wrdst;
                  retire_q   <= retire_d;
                  if (ex_halt) begin
                     halted_q <= 1'b1;
                     state_q  <= S_HALT;
                  end
               end
            end
            S_LOAD: begin
               wb_valid_q <= 1'b1;
               wb_lo_q    <= rdata_q;
               wb_hi_q    <= ld_hi_q;
               wb_dst_q   <= ld_dst_q;
               wb_wrdst_q <= ld_wrdst_q;
               retire_q   <= retire_d;
               state_q    <= S_RUN;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_RUN;
            end
         endcase
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_lo        = wb_lo_q;
   assign wb_hi        = wb_hi_q;
   assign wb_dst       = wb_dst_q;
   assign wb_wrdst     = wb_wrdst_q;
   assign halted       = halted_q;
   assign retire_count = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instruction stream, per-cycle comparison against
// a transaction-level model, plus hand-computed literal expectations.
`default_nettype none

module tb_mem_stage;

   localparam int ADDR_W = 8;
   localparam int CNT_W  = 4;

   logic             CLOCK = 1'b0;
   logic             CLEAR;
   logic             ex_valid;
   logic             ex_ready;
   logic [15:0]      ex_lo;
   logic [15:0]      ex_hi;
   logic [15:0]      ex_sdata;
   logic [3:0]       ex_dst;
   logic [1:0]       ex_wrdst;
   logic             ex_load;
   logic             ex_store;
   logic             ex_halt;
   logic             wb_valid;
   logic [15:0]      wb_lo;
   logic [15:0]      wb_hi;
   logic [3:0]       wb_dst;
   logic [1:0]       wb_wrdst;
   logic             halted;
   logic [CNT_W-1:0] retire_count;

   int n_pass  = 0;
   int n_total = 0;

   mem_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .CLOCK(CLOCK), .CLEAR(CLEAR),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_lo(ex_lo), .ex_hi(ex_hi), .ex_sdata(ex_sdata),
      .ex_dst(ex_dst), .ex_wrdst(ex_wrdst),
      .ex_load(ex_load), .ex_store(ex_store), .ex_halt(ex_halt),
      .wb_valid(wb_valid), .wb_lo(wb_lo), .wb_hi(wb_hi),
      .wb_dst(wb_dst), .wb_wrdst(wb_wrdst),
      .halted(halted), .retire_count(retire_count)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Transaction-level model: a data array, an optional pending load record,
   // a halted flag and the last delivered writeback bundle.
   logic [15:0]      m_mem [256];
   bit               m_halted;
   bit               m_pend;
   logic [7:0]       m_pend_addr;
   logic [15:0]      m_pend_hi;
   logic [3:0]       m_pend_dst;
   logic [1:0]       m_pend_wrdst;
   logic             e_valid;
   logic [15:0]      e_lo, e_hi;
   logic [3:0]       e_dst;
   logic [1:0]       e_wrdst;
   logic [CNT_W-1:0] e_cnt;

   task automatic deliver(input logic [15:0] lo, input logic [15:0] hi,
                          input logic [3:0] dst, input logic [1:0] wd);
      e_valid = 1'b1;
      e_lo    = lo;
      e_hi    = hi;
      e_dst   = dst;
      e_wrdst = wd;
      e_cnt   = e_cnt + 1'b1;
   endtask

   always @(posedge CLOCK) begin
      if (CLEAR) begin
         m_halted = 0; m_pend = 0;
         e_valid = 0; e_lo = 0; e_hi = 0; e_dst = 0; e_wrdst = 0; e_cnt = 0;
      end else begin
         e_valid = 1'b0;
         if (m_pend) begin
            deliver(m_mem[m_pend_addr], m_pend_hi, m_pend_dst, m_pend_wrdst);
            m_pend = 0;
         end else if (!m_halted && ex_valid) begin
            if (ex_halt) begin
               deliver(ex_lo, ex_hi, ex_dst, 2'b00);
               m_halted = 1;
            end else if (ex_store) begin
               m_mem[ex_lo % 256] = ex_sdata;
               deliver(ex_lo, ex_hi, ex_dst, 2'b00);
            end else if (ex_load) begin
               m_pend       = 1;
               m_pend_addr  = ex_lo[7:0];
               m_pend_hi    = ex_hi;
               m_pend_dst   = ex_dst;
               m_pend_wrdst = ex_wrdst;
            end else begin
               deliver(ex_lo, ex_hi, ex_dst, ex_wrdst);
            end
         end
      end
      #1;
      chk("m_ready",  32'(ex_ready), 32'(!m_halted && !m_pend));
      chk("m_valid",  32'(wb_valid), 32'(e_valid));
      chk("m_halted", 32'(halted), 32'(m_halted));
      chk("m_count",  32'(retire_count), 32'(e_cnt));
      chk("m_hi",     32'(wb_hi), 32'(e_hi));
      chk("m_dst",    32'(wb_dst), 32'(e_dst));
      chk("m_wrdst",  32'(wb_wrdst), 32'(e_wrdst));
      if (!$isunknown(e_lo)) chk("m_lo", 32'(wb_lo), 32'(e_lo));
   end

   task automatic step();
      @(posedge CLOCK);
      #2;
   endtask

   task automatic instr(input logic v, input logic [15:0] lo, input logic [15:0] hi,
                        input logic [15:0] sd, input logic [3:0] dst, input logic [1:0] wd,
                        input logic ld, input logic st, input logic hl);
      ex_valid = v; ex_lo = lo; ex_hi = hi; ex_sdata = sd;
      ex_dst = dst; ex_wrdst = wd; ex_load = ld; ex_store = st; ex_halt = hl;
   endtask

   initial begin
      CLEAR = 1'b1;
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      step(); step();
      CLEAR = 1'b0;
      #1;
      chk("rst_ready", 32'(ex_ready), 32'd1);
      chk("rst_valid", 32'(wb_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(retire_count), 32'd0);

      // ALU op
      instr(1, 16'h1234, 16'h00AB, 16'h0, 4'd3, 2'b01, 0, 0, 0);
      step();
      chk("alu_valid", 32'(wb_valid), 32'd1);
      chk("alu_lo", 32'(wb_lo), 32'h1234);
      chk("alu_hi", 32'(wb_hi), 32'h00AB);
      chk("alu_dst", 32'(wb_dst), 32'd3);
      chk("alu_wrdst", 32'(wb_wrdst), 32'd1);
      chk("alu_count", 32'(retire_count), 32'd1);

      // Store BEEF at addr 0x10 via 0x0110, then load via 0xFF10
      instr(1, 16'h0110, 16'h0000, 16'hBEEF, 4'd7, 2'b10, 0, 1, 0);
      step();
      chk("st_valid", 32'(wb_valid), 32'd1);
      chk("st_wrdst", 32'(wb_wrdst), 32'd0);
      instr(1, 16'hFF10, 16'h1111, 16'h0, 4'd5, 2'b01, 1, 0, 0);
      step();
      chk("ld_bubble_valid", 32'(wb_valid), 32'd0);
      chk("ld_bubble_ready", 32'(ex_ready), 32'd0);
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      step();
      chk("ld_lo", 32'(wb_lo), 32'hBEEF);
      chk("ld_dst", 32'(wb_dst), 32'd5);
      chk("ld_ready", 32'(ex_ready), 32'd1);
      chk("ld_count", 32'(retire_count), 32'd3);
      step();

      // Back-to-back ALU, load, ALU with ex_valid held high
      instr(1, 16'h0001, 16'h0, 16'h0, 4'd1, 2'b01, 0, 0, 0);
      step();
      instr(1, 16'h0010, 16'h0, 16'h0, 4'd2, 2'b01, 1, 0, 0);
      step();
      chk("b2b_bubble", 32'(wb_valid), 32'd0);
      instr(1, 16'h0003, 16'h0, 16'h0, 4'd4, 2'b01, 0, 0, 0);
      step();
      chk("b2b_ld_lo", 32'(wb_lo), 32'hBEEF);
      step();
      chk("b2b_alu_lo", 32'(wb_lo), 32'h0003);
      chk("b2b_count", 32'(retire_count), 32'd6);
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      step();

      // Halt (with ex_load also set), then ex_valid held high
      instr(1, 16'h0042, 16'h0, 16'h0, 4'd9, 2'b01, 1, 0, 1);
      step();
      chk("halt_valid", 32'(wb_valid), 32'd1);
      chk("halt_wrdst", 32'(wb_wrdst), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_ready", 32'(ex_ready), 32'd0);
      instr(1, 16'h0005, 16'h0, 16'h0, 4'd1, 2'b01, 0, 0, 0);
      step(); step(); step();
      chk("halt_count", 32'(retire_count), 32'd7);
      CLEAR = 1'b1;
      step();
      CLEAR = 1'b0;
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      #1;
      chk("clr_halted", 32'(halted), 32'd0);
      chk("clr_ready", 32'(ex_ready), 32'd1);

      // Reset mid-load: memory write retained, pending load discarded
      instr(1, 16'h0020, 16'h0, 16'h5A5A, 4'd0, 2'b00, 0, 1, 0);
      step();
      instr(1, 16'h0020, 16'h0, 16'h0, 4'd6, 2'b01, 1, 0, 0);
      step();
      CLEAR = 1'b1;
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      step();
      CLEAR = 1'b0;
      #1;
      chk("mid_valid", 32'(wb_valid), 32'd0);
      chk("mid_count", 32'(retire_count), 32'd0);
      instr(1, 16'h0320, 16'h0, 16'h0, 4'd6, 2'b01, 1, 0, 0);
      step();
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      step();
      chk("mid_lo", 32'(wb_lo), 32'h5A5A);
      chk("mid_count2", 32'(retire_count), 32'd1);

      // Counter wrap: 16 more retirements bring a 4-bit count back to 1
      for (int i = 0; i < 16; i++) begin
         instr(1, 16'(i), 16'(i * 3), 16'h0, 4'(i), 2'(i), 0, 0, 0);
         step();
      end
      instr(0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 0, 0, 0);
      chk("wrap_count", 32'(retire_count), 32'd1);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX stage (ALU + ALU_CONTROL + CONTROL).
- Consumes ALU results (lower/upper words), the register destination and WRITEDST code.
- Performs word load/store on an internal data memory and presents the writeback bundle to the register file.
- Provides a valid/ready handshake toward EX, halt capture, and a retired-instruction counter.

Parameters:
ADDR_W, 8, data memory address width; memory depth is 2**ADDR_W words of 16 bits
CNT_W, 16, width of retire_count

Ports:
CLOCK  input  1  system clock, all state updates on rising edge
CLEAR  input  1  asynchronous active-high reset
ex_valid  input  1  EX presents an instruction this cycle
ex_ready  output  1  stage can accept; transfer occurs when ex_valid && ex_ready at a rising edge
ex_lo  input  16  ALU lower result; also the memory address (bits ADDR_W-1:0)
ex_hi  input  16  ALU upper result (R15 path)
ex_sdata  input  16  store data (register operand 2)
ex_dst  input  4  destination register number
ex_wrdst  input  2  WRITEDST code from CONTROL, passed through
ex_load  input  1  instruction is a load
ex_store  input  1  instruction is a store
ex_halt  input  1  instruction is HALT
wb_valid  output  1  one-cycle pulse: writeback bundle valid
wb_lo  output  16  data for destination register (ALU lower result or loaded word)
wb_hi  output  16  data for R15
wb_dst  output  4  destination register number
wb_wrdst  output  2  WRITEDST code for the register file
halted  output  1  sticky: HALT has retired
retire_count  output  CNT_W  number of retired instructions

Behaviour:
- Reset (CLEAR=1, asynchronous): state=RUN; wb_valid=0, wb_lo=0, wb_hi=0, wb_dst=0, wb_wrdst=00, halted=0, retire_count=0. ex_ready=1 immediately after release. Memory contents are not affected by CLEAR (undefined until written).
- States: RUN, LOAD, HALT.
- ex_ready is combinational: 1 only in RUN, 0 in LOAD and HALT.
- RUN, accepted non-load, non-store:
  - Next edge: wb_valid=1, wb_lo=ex_lo, wb_hi=ex_hi, wb_dst=ex_dst, wb_wrdst=ex_wrdst.
  - Latency 1; stays in RUN.
- RUN, accepted store:
  - mem[ex_lo[ADDR_W-1:0]] <= ex_sdata on the accepting edge.
  - Same edge: wb_valid=1, wb_wrdst forced to 00 (no register write); other wb fields pass through.
- RUN, accepted load:
  - Accepting edge: memory read is registered; address, ex_dst and ex_wrdst are captured; go to LOAD; wb_valid=0 that cycle.
  - Next edge (LOAD): wb_valid=1, wb_lo=read word, wb_hi=captured ex_hi, wb_dst/wb_wrdst=captured values; return to RUN.
  - Latency 2; exactly one bubble toward EX.
- ex_load && ex_store both 1: treated as store, no load performed.
- Address wrap: only the low ADDR_W bits of ex_lo are used; upper bits are ignored.
- Read-after-write: a load accepted on any edge after a store to the same address returns the stored data. Store and load cannot be accepted on the same edge (one instruction per edge).
- RUN, accepted ex_halt=1:
  - Retires like a non-load with wb_wrdst forced to 00.
  - Next state HALT; halted=1 from the same edge.
  - HALT is absorbing until CLEAR: ex_ready=0, wb_valid=0.
  - ex_halt with ex_load=1: halt takes priority, no load.
- wb_valid is 0 in every cycle without a retirement; wb_* data fields hold their last values when wb_valid=0.
- retire_count: increments by 1 on every edge where wb_valid becomes 1 (the store and halt cases count). Wraps from 2**CNT_W-1 to 0.
- ex_valid=0 in RUN: no state change, wb_valid=0.
- CLEAR asserted mid-LOAD: the pending load is discarded, no wb_valid, state=RUN after release. Memory writes already performed are retained.
- No backpressure from writeback; the register file always accepts.

Test Plan:
- Reset: CLEAR=1 for 2 cycles, release -> ex_ready=1, wb_valid=0, halted=0, retire_count=0.
- ALU op: ex_lo=1234, ex_hi=00AB, ex_dst=3, ex_wrdst=01 -> next cycle wb_valid=1, wb_lo=1234, wb_hi=00AB, wb_dst=3, wb_wrdst=01; retire_count=1.
- Store then load: store ex_sdata=BEEF at ex_lo=0110 (addr 10); load ex_lo=FF10, ex_dst=5 -> ex_ready=0 for exactly one cycle, then wb_lo=BEEF, wb_dst=5, and the store's writeback shows wb_wrdst=00.
- Back-to-back: ALU, load, ALU with ex_valid held high -> wb_valid pulses at cycles 1, 3, 4; retire_count=3.
- Halt: accepted ex_halt=1 -> wb_valid pulse with wb_wrdst=00, halted=1, ex_ready=0 thereafter with ex_valid=1 held; retire_count stops changing; CLEAR restores RUN.
- Reset mid-load: accept load, assert CLEAR in the LOAD cycle -> no wb_valid. After release, a load from the same address returns the previously stored data. retire_count=0.
